// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: FSM state codes, opcodes,
// function-select encodings, mux select codes and ARF register selects.
package cu_pkg;

    // FSM state codes; the numeric value is exported on SeqCnt.
    typedef enum logic [2:0] {
        FETCH_L = 3'd0,
        FETCH_H = 3'd1,
        DECODE  = 3'd2,
        EXEC1   = 3'd3,
        EXEC2   = 3'd4,
        HALT    = 3'd7
    } state_t;

    // Opcodes with a dedicated meaning (0-7 are ALU operations).
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_BRA = 4'hA;
    localparam logic [3:0] OP_BEQ = 4'hB;
    localparam logic [3:0] OP_BNE = 4'hC;

    // Register-file / ARF function selects.
    localparam logic [1:0] FUN_CLR  = 2'b00;
    localparam logic [1:0] FUN_LOAD = 2'b01;
    localparam logic [1:0] FUN_DEC  = 2'b10;
    localparam logic [1:0] FUN_INC  = 2'b11;

    // MuxA sources (feeds the register file).
    localparam logic [1:0] MUXA_ALU = 2'b00;
    localparam logic [1:0] MUXA_IR  = 2'b01;
    localparam logic [1:0] MUXA_MEM = 2'b10;
    localparam logic [1:0] MUXA_ARF = 2'b11;

    // MuxB sources (feeds the address register file).
    localparam logic [1:0] MUXB_ALU   = 2'b00;
    localparam logic [1:0] MUXB_IR    = 2'b01;
    localparam logic [1:0] MUXB_MEM   = 2'b10;
    localparam logic [1:0] MUXB_CONST = 2'b11;

    // One-hot ARF register enables.
    localparam logic [3:0] ARF_PC = 4'b0100;
    localparam logic [3:0] ARF_AR = 4'b0010;
    localparam logic [3:0] ARF_SP = 4'b0001;

    // ARF output-port select codes.
    localparam logic [1:0] ARF_SEL_SP = 2'b01;
    localparam logic [1:0] ARF_SEL_AR = 2'b10;
    localparam logic [1:0] ARF_SEL_PC = 2'b11;

    // ALU function that passes operand A unchanged (used by stores).
    localparam logic [3:0] ALU_PASS_A = 4'b1000;

    // Enable-all pattern used to clear the register file on reset.
    localparam logic [3:0] RF_ALL = 4'b1111;

    // Position of the Z flag inside {Z,C,N,O}.
    localparam int FLAG_Z = 3;

    // Full control word driven towards the datapath.
    typedef struct packed {
        logic [1:0] rf_outa_sel;
        logic [1:0] rf_outb_sel;
        logic [1:0] rf_fun_sel;
        logic [3:0] rf_rsel;
        logic [3:0] rf_tsel;
        logic [3:0] alu_fun_sel;
        logic [3:0] arf_rsel;
        logic [1:0] arf_outa_sel;
        logic [1:0] arf_outb_sel;
        logic [1:0] arf_fun_sel;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       ir_lh;
        logic       ir_enable;
        logic       mux_c_sel;
        logic       mem_wr;
        logic       mem_cs;
    } ctrl_t;

    // Every enable inactive; memory chip select is active-low so it idles high.
    localparam ctrl_t CTRL_IDLE = '{
        rf_outa_sel:  2'b00,
        rf_outb_sel:  2'b00,
        rf_fun_sel:   2'b00,
        rf_rsel:      4'b0000,
        rf_tsel:      4'b0000,
        alu_fun_sel:  4'b0000,
        arf_rsel:     4'b0000,
        arf_outa_sel: 2'b00,
        arf_outb_sel: 2'b00,
        arf_fun_sel:  2'b00,
        mux_a_sel:    2'b00,
        mux_b_sel:    2'b00,
        ir_lh:        1'b0,
        ir_enable:    1'b0,
        mux_c_sel:    1'b0,
        mem_wr:       1'b0,
        mem_cs:       1'b1
    };

    // Register-file enable for a 2-bit register index; R0 sits in the MSB.
    function automatic logic [3:0] rf_onehot(input logic [1:0] idx);
        return 4'b1000 >> idx;
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational control-word decoder: maps (reset, state, opcode, IR, flags)
// to the datapath control word.
// Optional feature macro: CU_COND_BRANCH_EN enables BEQ (0xB) / BNE (0xC);
// without it those opcodes behave as NOP.
module cu_decoder
    import cu_pkg::*;
(
    input  logic        rst_i,
    input  state_t      state_i,
    input  logic [3:0]  opcode_i,
    input  logic [15:0] ir_i,
    input  logic [3:0]  flags_i,
    output ctrl_t       ctrl_o
);

    logic [1:0] dst;
    logic [1:0] src1;
    logic [1:0] src2;
    logic       unused_bits;

    assign dst  = ir_i[11:10];
    assign src1 = ir_i[9:8];
    assign src2 = ir_i[7:6];

    // Opcode comes from the latched register, IMM is routed by the datapath
    // muxes, so these IR bits and the non-zero flags are not needed here.
`ifdef CU_COND_BRANCH_EN
    assign unused_bits = ^{ir_i[15:12], ir_i[5:0], flags_i[2:0]};
`else
    assign unused_bits = ^{ir_i[15:12], ir_i[5:0], flags_i};
`endif

    // Build the control word; reset overrides every state.
    always_comb begin
        logic pc_load;
        ctrl_o  = CTRL_IDLE;
        pc_load = 1'b0;
        if (rst_i) begin
            ctrl_o.arf_fun_sel = FUN_LOAD;
            ctrl_o.arf_rsel    = ARF_PC;
            ctrl_o.mux_b_sel   = MUXB_CONST;
            ctrl_o.rf_fun_sel  = FUN_CLR;
            ctrl_o.rf_rsel     = RF_ALL;
            ctrl_o.rf_tsel     = RF_ALL;
        end else begin
            case (state_i)
                FETCH_L, FETCH_H: begin
                    ctrl_o.mem_cs       = 1'b0;
                    ctrl_o.arf_outb_sel = ARF_SEL_PC;
                    ctrl_o.ir_enable    = 1'b1;
                    ctrl_o.ir_lh        = (state_i == FETCH_H);
                    ctrl_o.arf_fun_sel  = FUN_INC;
                    ctrl_o.arf_rsel     = ARF_PC;
                end
                EXEC1: begin
                    if (!opcode_i[3]) begin
                        ctrl_o.rf_outa_sel = src1;
                        ctrl_o.rf_outb_sel = src2;
                        ctrl_o.alu_fun_sel = {1'b0, opcode_i[2:0]};
                        ctrl_o.mux_a_sel   = MUXA_ALU;
                        ctrl_o.rf_fun_sel  = FUN_LOAD;
                        ctrl_o.rf_rsel     = rf_onehot(dst);
                    end else begin
                        case (opcode_i)
                            OP_LDI: begin
                                ctrl_o.mux_a_sel  = MUXA_IR;
                                ctrl_o.rf_fun_sel = FUN_LOAD;
                                ctrl_o.rf_rsel    = rf_onehot(dst);
                            end
                            OP_ST: begin
                                ctrl_o.rf_outa_sel  = dst;
                                ctrl_o.alu_fun_sel  = ALU_PASS_A;
                                ctrl_o.mem_cs       = 1'b0;
                                ctrl_o.mem_wr       = 1'b1;
                                ctrl_o.arf_outb_sel = ARF_SEL_AR;
                            end
                            OP_BRA: pc_load = 1'b1;
`ifdef CU_COND_BRANCH_EN
                            OP_BEQ: pc_load = flags_i[FLAG_Z];
                            OP_BNE: pc_load = !flags_i[FLAG_Z];
`endif
                            default: ;
                        endcase
                    end
                    if (pc_load) begin
                        ctrl_o.mux_b_sel   = MUXB_IR;
                        ctrl_o.arf_fun_sel = FUN_LOAD;
                        ctrl_o.arf_rsel    = ARF_PC;
                    end
                end
                EXEC2: begin
                    // Second half of a store: AR takes IMM.
                    if (opcode_i == OP_ST) begin
                        ctrl_o.mux_b_sel   = MUXB_IR;
                        ctrl_o.arf_fun_sel = FUN_LOAD;
                        ctrl_o.arf_rsel    = ARF_AR;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Control unit top: instruction sequencing FSM and latched opcode; the
// control word itself comes from cu_decoder.
// Optional feature macro: CU_COND_BRANCH_EN (conditional branches BEQ/BNE).
module control_unit
    import cu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [3:0] HALT_OP  = 4'hF
)
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [1:0]  RF_OutASel,
    output logic [1:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RSel,
    output logic [3:0]  RF_TSel,
    output logic [3:0]  ALU_FunSel,
    output logic [3:0]  ARF_RSel,
    output logic [1:0]  ARF_OutASel,
    output logic [1:0]  ARF_OutBSel,
    output logic [1:0]  ARF_FunSel,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic        MuxCSel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [2:0]  SeqCnt,
    output logic        Halted
);

    state_t     state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    ctrl_t      ctrl;
    logic [7:0] unused_reset_pc;

    // RESET_PC is the value the datapath constant source presents when
    // MuxBSel selects CONST; the sequencer itself never needs it.
    assign unused_reset_pc = RESET_PC;

    // State and opcode registers; reset wins over every transition.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= FETCH_L;
            opcode_q <= 4'h0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Next-state and opcode-latch logic.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            FETCH_L: state_d = FETCH_H;
            FETCH_H: state_d = DECODE;
            DECODE: begin
                opcode_d = IROut[15:12];
                state_d  = (IROut[15:12] == HALT_OP) ? HALT : EXEC1;
            end
            EXEC1:   state_d = (opcode_q == OP_ST) ? EXEC2 : FETCH_L;
            EXEC2:   state_d = FETCH_L;
            HALT:    state_d = HALT;
            default: state_d = FETCH_L;
        endcase
    end

    cu_decoder u_decoder (
        .rst_i    (Reset),
        .state_i  (state_q),
        .opcode_i (opcode_q),
        .ir_i     (IROut),
        .flags_i  (ALUOutFlag),
        .ctrl_o   (ctrl)
    );

    assign RF_OutASel  = ctrl.rf_outa_sel;
    assign RF_OutBSel  = ctrl.rf_outb_sel;
    assign RF_FunSel   = ctrl.rf_fun_sel;
    assign RF_RSel     = ctrl.rf_rsel;
    assign RF_TSel     = ctrl.rf_tsel;
    assign ALU_FunSel  = ctrl.alu_fun_sel;
    assign ARF_RSel    = ctrl.arf_rsel;
    assign ARF_OutASel = ctrl.arf_outa_sel;
    assign ARF_OutBSel = ctrl.arf_outb_sel;
    assign ARF_FunSel  = ctrl.arf_fun_sel;
    assign MuxASel     = ctrl.mux_a_sel;
    assign MuxBSel     = ctrl.mux_b_sel;
    assign IR_LH       = ctrl.ir_lh;
    assign IR_Enable   = ctrl.ir_enable;
    assign MuxCSel     = ctrl.mux_c_sel;
    assign Mem_WR      = ctrl.mem_wr;
    assign Mem_CS      = ctrl.mem_cs;
    assign SeqCnt      = state_q;
    assign Halted      = (state_q == HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: expected output words are queued as each
// step is driven and popped for comparison once the DUT has moved.
module tb_control_unit;
    import cu_pkg::*;

    logic        Clock;
    logic        Reset;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel, ARF_RSel;
    logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel, MuxASel, MuxBSel;
    logic        IR_LH, IR_Enable, MuxCSel, Mem_WR, Mem_CS;
    logic [2:0]  SeqCnt;
    logic        Halted;

    typedef struct packed {
        logic [1:0] rf_outa_sel;
        logic [1:0] rf_outb_sel;
        logic [1:0] rf_fun_sel;
        logic [3:0] rf_rsel;
        logic [3:0] rf_tsel;
        logic [3:0] alu_fun_sel;
        logic [3:0] arf_rsel;
        logic [1:0] arf_outa_sel;
        logic [1:0] arf_outb_sel;
        logic [1:0] arf_fun_sel;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
        logic       ir_lh;
        logic       ir_enable;
        logic       mux_c_sel;
        logic       mem_wr;
        logic       mem_cs;
        logic [2:0] seq;
        logic       halted;
    } obs_t;

    obs_t  obs;
    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    control_unit #(.RESET_PC(8'h10), .HALT_OP(4'hF)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .IROut       (IROut),
        .ALUOutFlag  (ALUOutFlag),
        .RF_OutASel  (RF_OutASel),
        .RF_OutBSel  (RF_OutBSel),
        .RF_FunSel   (RF_FunSel),
        .RF_RSel     (RF_RSel),
        .RF_TSel     (RF_TSel),
        .ALU_FunSel  (ALU_FunSel),
        .ARF_RSel    (ARF_RSel),
        .ARF_OutASel (ARF_OutASel),
        .ARF_OutBSel (ARF_OutBSel),
        .ARF_FunSel  (ARF_FunSel),
        .MuxASel     (MuxASel),
        .MuxBSel     (MuxBSel),
        .IR_LH       (IR_LH),
        .IR_Enable   (IR_Enable),
        .MuxCSel     (MuxCSel),
        .Mem_WR      (Mem_WR),
        .Mem_CS      (Mem_CS),
        .SeqCnt      (SeqCnt),
        .Halted      (Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always_comb begin
        obs.rf_outa_sel  = RF_OutASel;
        obs.rf_outb_sel  = RF_OutBSel;
        obs.rf_fun_sel   = RF_FunSel;
        obs.rf_rsel      = RF_RSel;
        obs.rf_tsel      = RF_TSel;
        obs.alu_fun_sel  = ALU_FunSel;
        obs.arf_rsel     = ARF_RSel;
        obs.arf_outa_sel = ARF_OutASel;
        obs.arf_outb_sel = ARF_OutBSel;
        obs.arf_fun_sel  = ARF_FunSel;
        obs.mux_a_sel    = MuxASel;
        obs.mux_b_sel    = MuxBSel;
        obs.ir_lh        = IR_LH;
        obs.ir_enable    = IR_Enable;
        obs.mux_c_sel    = MuxCSel;
        obs.mem_wr       = Mem_WR;
        obs.mem_cs       = Mem_CS;
        obs.seq          = SeqCnt;
        obs.halted       = Halted;
    end

    // Expected-word builders.
    function automatic obs_t w_idle(input logic [2:0] seq);
        obs_t w;
        w        = '0;
        w.mem_cs = 1'b1;
        w.seq    = seq;
        w.halted = (seq == 3'd7);
        return w;
    endfunction

    function automatic obs_t w_fetch(input logic lh);
        obs_t w;
        w              = w_idle(lh ? 3'd1 : 3'd0);
        w.mem_cs       = 1'b0;
        w.arf_outb_sel = ARF_SEL_PC;
        w.ir_enable    = 1'b1;
        w.ir_lh        = lh;
        w.arf_fun_sel  = FUN_INC;
        w.arf_rsel     = ARF_PC;
        return w;
    endfunction

    function automatic obs_t w_rst(input logic [2:0] seq);
        obs_t w;
        w             = w_idle(seq);
        w.arf_fun_sel = FUN_LOAD;
        w.arf_rsel    = ARF_PC;
        w.mux_b_sel   = MUXB_CONST;
        w.rf_fun_sel  = FUN_CLR;
        w.rf_rsel     = 4'b1111;
        w.rf_tsel     = 4'b1111;
        return w;
    endfunction

    function automatic obs_t w_alu(input logic [15:0] ir, input logic [3:0] rsel);
        obs_t w;
        w             = w_idle(3'd3);
        w.rf_outa_sel = ir[9:8];
        w.rf_outb_sel = ir[7:6];
        w.alu_fun_sel = {1'b0, ir[14:12]};
        w.mux_a_sel   = MUXA_ALU;
        w.rf_fun_sel  = FUN_LOAD;
        w.rf_rsel     = rsel;
        return w;
    endfunction

    function automatic obs_t w_ldi(input logic [3:0] rsel);
        obs_t w;
        w            = w_idle(3'd3);
        w.mux_a_sel  = MUXA_IR;
        w.rf_fun_sel = FUN_LOAD;
        w.rf_rsel    = rsel;
        return w;
    endfunction

    function automatic obs_t w_st1(input logic [1:0] dst);
        obs_t w;
        w              = w_idle(3'd3);
        w.rf_outa_sel  = dst;
        w.alu_fun_sel  = ALU_PASS_A;
        w.mem_cs       = 1'b0;
        w.mem_wr       = 1'b1;
        w.arf_outb_sel = ARF_SEL_AR;
        return w;
    endfunction

    function automatic obs_t w_st2();
        obs_t w;
        w             = w_idle(3'd4);
        w.arf_fun_sel = FUN_LOAD;
        w.arf_rsel    = ARF_AR;
        w.mux_b_sel   = MUXB_IR;
        return w;
    endfunction

    function automatic obs_t w_pcload();
        obs_t w;
        w             = w_idle(3'd3);
        w.mux_b_sel   = MUXB_IR;
        w.arf_fun_sel = FUN_LOAD;
        w.arf_rsel    = ARF_PC;
        return w;
    endfunction

    // Pop the oldest expectation and compare it with the current outputs.
    task automatic compare_head();
        obs_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e)
        else begin
            errors++;
            $error("FAIL %s: observed %h required %h", t, obs, e);
        end
    endtask

    // Queue an expectation, let one clock edge pass, then check.
    task automatic step(input string t, input obs_t e);
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge Clock);
        #1;
        compare_head();
    endtask

    // Queue an expectation for the current cycle after an input change.
    task automatic check_now(input string t, input obs_t e);
        exp_q.push_back(e);
        tag_q.push_back(t);
        #1;
        compare_head();
    endtask

    task automatic front(input string t);
        step({t, "_fetch_h"}, w_fetch(1'b1));
        step({t, "_decode"}, w_idle(3'd2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset      = 1'b1;
        IROut      = 16'h0000;
        ALUOutFlag = 4'b0000;

        step("reset_cycle", w_rst(3'd0));
        step("reset_hold", w_rst(3'd0));
        Reset = 1'b0;
        check_now("fetch_l_after_reset", w_fetch(1'b0));

        // ADD-class: DST=1 -> RSel 0100, SRC1=2, SRC2=1
        IROut = 16'h0650;
        front("add");
        step("add_exec1", w_alu(16'h0650, 4'b0100));
        step("add_fetch_l", w_fetch(1'b0));

        IROut = 16'hA020;
        front("bra");
        step("bra_exec1", w_pcload());
        step("bra_fetch_l", w_fetch(1'b0));

        IROut = 16'h8C5A;
        front("ldi");
        step("ldi_exec1", w_ldi(4'b0001));
        step("ldi_fetch_l", w_fetch(1'b0));

        IROut = 16'h9833;
        front("st");
        step("st_exec1", w_st1(2'd2));
        step("st_exec2", w_st2());
        step("st_fetch_l", w_fetch(1'b0));

        IROut = 16'h5E40;
        front("op5");
        step("op5_exec1", w_alu(16'h5E40, 4'b0001));
        step("op5_fetch_l", w_fetch(1'b0));

        IROut = 16'h7B80;
        front("op7");
        step("op7_exec1", w_alu(16'h7B80, 4'b0010));
        step("op7_fetch_l", w_fetch(1'b0));

        IROut      = 16'hB040;
        ALUOutFlag = 4'b1000;
        front("beq_z1");
`ifdef CU_COND_BRANCH_EN
        step("beq_z1_exec1", w_pcload());
`else
        step("beq_z1_exec1", w_idle(3'd3));
`endif
        step("beq_z1_fetch_l", w_fetch(1'b0));

        IROut = 16'hC040;
        front("bne_z1");
        step("bne_z1_exec1", w_idle(3'd3));
        step("bne_z1_fetch_l", w_fetch(1'b0));

        ALUOutFlag = 4'b0000;
        front("bne_z0");
`ifdef CU_COND_BRANCH_EN
        step("bne_z0_exec1", w_pcload());
`else
        step("bne_z0_exec1", w_idle(3'd3));
`endif
        step("bne_z0_fetch_l", w_fetch(1'b0));

        IROut = 16'hD123;
        front("nop_d");
        step("nop_d_exec1", w_idle(3'd3));
        step("nop_d_fetch_l", w_fetch(1'b0));

        // Reset while in FETCH_H
        step("mid_fetch_h", w_fetch(1'b1));
        Reset = 1'b1;
        check_now("rst_comb_in_fetch_h", w_rst(3'd1));
        step("rst_from_fetch_h", w_rst(3'd0));
        Reset = 1'b0;
        check_now("fetch_l_after_mid_rst", w_fetch(1'b0));

        // Reset in DECODE must beat the HALT transition
        IROut = 16'hF000;
        front("rst_vs_halt");
        Reset = 1'b1;
        step("rst_over_halt", w_rst(3'd0));
        Reset = 1'b0;
        check_now("fetch_l_after_rst_vs_halt", w_fetch(1'b0));

        // HALT holds for ten cycles regardless of IR
        front("halt");
        for (int i = 0; i < 10; i++) begin
            if (i == 3) IROut = 16'h0650;
            step($sformatf("halt_hold_%0d", i), w_idle(3'd7));
        end
        Reset = 1'b1;
        step("rst_from_halt", w_rst(3'd0));
        Reset = 1'b0;
        check_now("fetch_l_after_halt", w_fetch(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00, value loaded into PC on reset.
REQ-002 Parameter HALT_OP, default 4'hF, opcode that enters HALT.
REQ-003 Clock  in  1  system clock; all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 IROut  in  16  IR contents: [15:12] opcode, [11:10] DST, [9:8] SRC1, [7:6] SRC2, [7:0] IMM/target.
REQ-006 ALUOutFlag  in  4  {Z,C,N,O} from the ALU flag register.
REQ-007 RF_OutASel, RF_OutBSel, RF_FunSel  out  2 each  register-file controls.
REQ-008 RF_RSel, RF_TSel, ALU_FunSel, ARF_RSel  out  4 each  register/ALU controls; RSel/TSel one-hot enables.
REQ-009 ARF_OutASel, ARF_OutBSel, ARF_FunSel, MuxASel, MuxBSel  out  2 each  ARF and mux controls.
REQ-010 IR_LH, IR_Enable, MuxCSel, Mem_WR, Mem_CS  out  1 each  IR/mux/memory controls; Mem_CS active-low, Mem_WR=1 writes.
REQ-011 SeqCnt  out  3  current state code; Halted  out  1  high in HALT.

Function
REQ-012 The FSM SHALL have states FETCH_L(0), FETCH_H(1), DECODE(2), EXEC1(3), EXEC2(4), HALT(7), one state per cycle.
REQ-013 In every state, all enables SHALL default inactive: RF_RSel=RF_TSel=ARF_RSel=0, IR_Enable=0, Mem_CS=1, Mem_WR=0; other fields 0.
REQ-014 FETCH_L SHALL drive Mem_CS=0, ARF_OutBSel=PC, IR_Enable=1, IR_FunSel load, IR_LH=0, and increment PC (ARF_FunSel=11, ARF_RSel=PC bit); next FETCH_H.
REQ-015 FETCH_H SHALL do the same with IR_LH=1; next DECODE.
REQ-016 DECODE SHALL issue no enables and latch IROut[15:12] into an internal opcode register; next EXEC1, or HALT if opcode==HALT_OP.
REQ-017 Opcodes 0-7 (ALU ops) SHALL drive RF_OutASel=SRC1, RF_OutBSel=SRC2, ALU_FunSel={1'b0,op[2:0]}, MuxASel=ALUOut, RF_FunSel=01, RF_RSel=onehot(DST) in EXEC1; EXEC2 skipped; next FETCH_L.
REQ-018 Opcode 8 (LDI) SHALL load IMM into RF[DST] via MuxASel=IR in EXEC1; next FETCH_L.
REQ-019 Opcode 9 (ST) SHALL drive RF_OutASel=DST, ALU pass-A, Mem_CS=0, Mem_WR=1, ARF_OutBSel=AR in EXEC1, then load AR from IMM in EXEC2; next FETCH_L.
REQ-020 Opcode A (BRA) SHALL load PC with IMM via MuxBSel=IR, ARF_FunSel=01 in EXEC1.
REQ-021 Opcodes B-E without a defined meaning SHALL execute as NOP: EXEC1 with no enables, then FETCH_L.
REQ-022 PC SHALL wrap 8'hFF -> 8'h00 on increment with no side effect.
REQ-023 HALT SHALL hold all enables inactive and remain until Reset; Halted=1.
REQ-024 Reset asserted in any state, including mid-fetch, SHALL win over all transitions.

Reset
REQ-025 On Reset the FSM SHALL enter FETCH_L, SeqCnt=0, Halted=0, opcode register=0.
REQ-026 During the Reset cycle outputs SHALL drive ARF_FunSel=01, ARF_RSel=PC bit, MuxBSel=CONST, loading RESET_PC; RF_FunSel=00 with RF_RSel=RF_TSel=4'b1111 clears the register file.

Configuration
REQ-027 With CU_COND_BRANCH_EN defined, opcode B (BEQ) SHALL load PC from IMM iff ALUOutFlag[3]=1, and opcode C (BNE) iff ALUOutFlag[3]=0, in EXEC1.
REQ-028 Without CU_COND_BRANCH_EN, opcodes B and C SHALL execute as NOP.

Structure
REQ-029 A shared package cu_pkg SHALL hold the state enum, opcode constants, FunSel encodings (00 clear, 01 load, 10 dec, 11 inc), mux select codes and one-hot ARF register constants (PC, AR, SP).
REQ-030 Decode SHALL live in one combinational sub-module cu_decoder (opcode, state, flags -> control word); control_unit holds only the FSM and opcode register.

Verification
REQ-031 Reset with RESET_PC=8'h10 -> next cycle SeqCnt=0, Mem_CS=0, IR_Enable=1, IR_LH=0, ARF_OutBSel=PC.
REQ-032 IROut=16'h0650 (ADD-class, DST=1, SRC1=2, SRC2=1) -> EXEC1 RF_RSel=4'b0100, ALU_FunSel=4'b0000; FETCH_L follows at cycle 4.
REQ-033 IROut=16'hA020 (BRA 8'h20) -> EXEC1 ARF_FunSel=01, ARF_RSel=PC bit; next FETCH_L with ARF_OutBSel=PC.
REQ-034 With CU_COND_BRANCH_EN, IROut=16'hC040 and ALUOutFlag=4'b1000 -> no PC load; with 4'b0000 -> PC load asserted.
REQ-035 IROut=16'hF000 -> HALT after DECODE, Halted=1 for 10 cycles, all enables inactive; Reset then returns SeqCnt=0.
REQ-036 Reset asserted in FETCH_H -> next cycle FETCH_L, IR_LH=0, Halted=0.
